// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared bounds and response-pipeline stage type for data_ram_pipe.
package data_ram_pkg;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;
    typedef struct packed {
        logic valid;
        logic err;
        logic is_read;
    } resp_t;
endpackage

// File: rtl/data_ram_pipe_ram_sp_be.sv
// ram_sp_be: single-port byte-enabled word RAM with a registered read port.
module ram_sp_be
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 4096,
    localparam int BE_W = DATA_W / 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_d, rdata_q;
    // Read port returns zero on non-read cycles so downstream stages need no masking.
    always_comb rdata_d = (en && !we) ? mem[idx] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else rdata_q <= rdata_d;
    end
    always_ff @(posedge clk) begin
        if (en && we)
            for (int b = 0; b < BE_W; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: windowed byte-enabled data RAM slave with configurable read
// latency and an outstanding-request limiter on gnt.
module data_ram_pipe
    import data_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int LATENCY = 1,
    parameter int MAX_OUT = LATENCY
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    output logic                gnt,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;
    localparam int OFF_LSB = $clog2(BE_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [63:0] WIN_BYTES = 64'(DEPTH) * 64'(BE_W);

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
        $error("data_ram_pipe: LATENCY must be 1..4");
    end
    if (MAX_OUT < 1 || MAX_OUT > LATENCY) begin : g_bad_max_out
        $error("data_ram_pipe: MAX_OUT must be 1..LATENCY");
    end
    if (DATA_W < 8 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("data_ram_pipe: DATA_W must be a multiple of 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_ram_pipe: DEPTH must be a power of 2");
    end
    if (64'(BASE_ADDR) % WIN_BYTES != 0) begin : g_bad_base
        $error("data_ram_pipe: BASE_ADDR must be window aligned");
    end

    logic [ADDR_W-1:0] off;
    logic in_win;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    resp_t [LATENCY-1:0] pipe_d, pipe_q;
    logic [DATA_W-1:0] ram_rdata, rdata_end;

    // A response retiring this cycle frees its slot for a same-cycle accept.
    always_comb begin
        off = addr - BASE_ADDR;
        in_win = 64'(off) < WIN_BYTES;
        gnt = req && (cnt_q < CNT_W'(MAX_OUT) || (rvalid && cnt_q == CNT_W'(MAX_OUT)));
        cnt_d = cnt_q + CNT_W'(gnt) - CNT_W'(rvalid);
        pipe_d[0] = '{valid: gnt, err: gnt && !in_win, is_read: gnt && !we};
        for (int s = 1; s < LATENCY; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pipe_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            pipe_q <= pipe_d;
        end
    end

    ram_sp_be #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (gnt && in_win),
        .we   (we),
        .be   (be),
        .idx  (off[OFF_LSB +: IDX_W]),
        .wdata(wdata),
        .rdata(ram_rdata)
    );

    if (LATENCY > 1) begin : g_dpipe
        logic [LATENCY-2:0][DATA_W-1:0] dat_d, dat_q;
        always_comb begin
            dat_d[0] = ram_rdata;
            for (int s = 1; s < LATENCY - 1; s++) dat_d[s] = dat_q[s-1];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dat_q <= '0;
            else dat_q <= dat_d;
        end
        assign rdata_end = dat_q[LATENCY-2];
    end else begin : g_nopipe
        assign rdata_end = ram_rdata;
    end

    assign rvalid = pipe_q[LATENCY-1].valid;
    assign err = pipe_q[LATENCY-1].err;
    assign rdata = pipe_q[LATENCY-1].is_read ? rdata_end : '0;
endmodule
